// File: rtl/ffd_delay_line.sv
// ---------------------------------------------------------------------------
// ffd_delay_line
//
// Multi-stage D flip-flop delay line. A WD-bit word and its valid qualifier
// travel together through DEPTH register stages. The output tap can be chosen
// at run time, so the delay can be set anywhere from 1 to DEPTH enabled clock
// edges. It also provides a stall (en), a synchronous flush of the valid bits
// and a count of the stages that currently hold valid data.
//
// Qualifier semantics: this block has no ready signal, so there is no
// backpressure. On an enabled edge (en=1, flush=0) a word is accepted
// whatever d_valid is. d_valid only marks whether that word counts. The data
// at the selected tap is meaningful only while q_valid=1.
//
// Ports
//   clk      in   1         clock; all state updates on the rising edge
//   reset    in   1         asynchronous, active-low reset
//   en       in   1         shift enable; 0 holds every stage
//   flush    in   1         synchronous clear of all valid bits (beats en)
//   d        in   WD        data into stage 0
//   d_valid  in   1         qualifier for d
//   tap_sel  in   TW        output tap; delay = tap_sel+1 enabled edges
//   q        out  WD        data at the selected tap
//   q_valid  out  1         valid bit at the selected tap
//   vld_cnt  out  CW        number of stages holding valid data (0..DEPTH)
// ---------------------------------------------------------------------------
module ffd_delay_line #(
   parameter int            WD      = 8,
   parameter int            DEPTH   = 4,
   parameter logic [WD-1:0] RST_VAL = '0,
   localparam int           TW      = (DEPTH > 2) ? $clog2(DEPTH) : 1,
   localparam int           CW      = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          flush,
   input  logic [WD-1:0] d,
   input  logic          d_valid,
   input  logic [TW-1:0] tap_sel,
   output logic [WD-1:0] q,
   output logic          q_valid,
   output logic [CW-1:0] vld_cnt
);

   logic [WD-1:0]    s [DEPTH];
   logic [DEPTH-1:0] v;
   logic [TW-1:0]    tap_idx;

   // Stage 0 is the youngest stage. An enabled edge moves every stage one
   // place toward DEPTH-1, and the contents of the last stage are lost.
   // A flush clears only the valid bits. The data stages keep their values
   // because nothing downstream looks at them while they are invalid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            s[i] <= RST_VAL;
         end
         v <= '0;
      end else if (flush) begin
         v <= '0;
      end else if (en) begin
         s[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            s[i] <= s[i-1];
         end
         v <= {v[DEPTH-2:0], d_valid};
      end
   end

   // When DEPTH is not a power of two, tap_sel can name a stage that does not
   // exist. Such a request is clamped to the last stage.
   always_comb begin
      tap_idx = tap_sel;
      if (int'(tap_sel) >= DEPTH) begin
         tap_idx = TW'(DEPTH - 1);
      end
   end

   assign q       = s[tap_idx];
   assign q_valid = v[tap_idx];

   always_comb begin
      vld_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         vld_cnt = vld_cnt + CW'(v[i]);
      end
   end

endmodule

// File: tb/tb_ffd_delay_line.sv
// ---------------------------------------------------------------------------
// tb_ffd_delay_line
//
// Bench for ffd_delay_line. Two instances share the clock and reset: one with
// DEPTH=4 and one with DEPTH=5, the second for the tap clamp. Checks are
// built from:
//   - a vector table. Each record holds the inputs for one step and the
//     outputs expected after it. A step is either one clock edge or a
//     combinational settle only.
//   - hand-written sequences for an asynchronous reset in the middle of a
//     stream and for the clamped tap.
//   - a random stream with stalls, checked against a scoreboard queue of
//     expected words, with the latency of each word counted in enabled edges.
// ---------------------------------------------------------------------------
module tb_ffd_delay_line;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT (DEPTH=4) ----------------
   logic       en4 = 1'b0, flush4 = 1'b0, dv4 = 1'b0;
   logic [7:0] d4 = '0, q4;
   logic [1:0] tap4 = '0;
   logic       qv4;
   logic [2:0] cnt4;

   ffd_delay_line #(.WD(8), .DEPTH(4), .RST_VAL(8'h00)) u_dut4 (
      .clk(clk), .reset(reset), .en(en4), .flush(flush4), .d(d4),
      .d_valid(dv4), .tap_sel(tap4), .q(q4), .q_valid(qv4), .vld_cnt(cnt4)
   );

   // ---------------- DUT (DEPTH=5) ----------------
   logic       en5 = 1'b0, flush5 = 1'b0, dv5 = 1'b0;
   logic [7:0] d5 = '0, q5;
   logic [2:0] tap5 = '0;
   logic       qv5;
   logic [2:0] cnt5;

   ffd_delay_line #(.WD(8), .DEPTH(5), .RST_VAL(8'h00)) u_dut5 (
      .clk(clk), .reset(reset), .en(en5), .flush(flush5), .d(d5),
      .d_valid(dv5), .tap_sel(tap5), .q(q5), .q_valid(qv5), .vld_cnt(cnt5)
   );

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   int         lat_q[$];

   typedef struct {
      bit       clk_it;   // 1: apply the inputs and take one edge; 0: settle only
      bit       en;
      bit       flush;
      bit [7:0] d;
      bit       dv;
      bit [1:0] tap;
      bit [7:0] eq;
      bit       eqv;
      bit [2:0] ecnt;
      string    name;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input bit clk_it, input bit en, input bit flush,
                      input bit [7:0] d, input bit dv, input bit [1:0] tap,
                      input bit [7:0] eq, input bit eqv, input bit [2:0] ecnt,
                      input string name);
      vec_t r;
      r.clk_it = clk_it; r.en = en; r.flush = flush; r.d = d; r.dv = dv;
      r.tap = tap; r.eq = eq; r.eqv = eqv; r.ecnt = ecnt; r.name = name;
      tbl.push_back(r);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int en_edges;
      logic [7:0] wd;
      int lat;

      // Reset is held while the clock runs.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_q",   q4,   8'h00);
      chk("rst_qv",  qv4,  1'b0);
      chk("rst_cnt", cnt4, 3'd0);
      chk("rst_cnt5", cnt5, 3'd0);
      reset = 1'b1;

      // Vector table. The stage contents are worked out in the comments.
      //   clk en fl d     dv tap eq    eqv cnt
      add(1, 1, 0, 8'hA5, 1, 0, 8'hA5, 1, 3'd1, "a5_in");     // v=0001
      add(1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 3'd1, "a5_w1");     // v=0010
      add(1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 3'd1, "a5_w2");     // v=0100
      add(1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 3'd1, "a5_w3");     // v=1000
      add(1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 3'd0, "a5_out");    // v=0000
      add(1, 1, 0, 8'h11, 1, 3, 8'h00, 0, 3'd1, "st_11");
      add(1, 1, 0, 8'h22, 1, 3, 8'h00, 0, 3'd2, "st_22");
      add(1, 1, 0, 8'h33, 1, 3, 8'h00, 0, 3'd3, "st_33");
      add(1, 1, 0, 8'h44, 1, 3, 8'h11, 1, 3'd4, "st_44");     // s=44,33,22,11
      add(0, 0, 0, 8'h00, 0, 1, 8'h33, 1, 3'd4, "tap_sw1");   // no edge
      add(1, 0, 0, 8'h00, 0, 1, 8'h33, 1, 3'd4, "stall1");
      add(1, 0, 0, 8'h00, 0, 1, 8'h33, 1, 3'd4, "stall2");
      add(1, 1, 0, 8'h55, 1, 1, 8'h44, 1, 3'd4, "resume");    // s=55,44,33,22
      add(1, 1, 1, 8'h77, 1, 1, 8'h00, 0, 3'd0, "flush");
      add(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 3'd0, "flush_t0");
      add(0, 0, 0, 8'h00, 0, 2, 8'h00, 0, 3'd0, "flush_t2");
      add(0, 0, 0, 8'h00, 0, 3, 8'h00, 0, 3'd0, "flush_t3");
      add(1, 1, 0, 8'h88, 1, 0, 8'h88, 1, 3'd1, "post_fl");   // s=88,55,44,33
      add(1, 1, 0, 8'h00, 0, 3, 8'h00, 0, 3'd1, "no_77");     // s3=44, invalid

      for (int i = 0; i < tbl.size(); i++) begin
         en4 = tbl[i].en; flush4 = tbl[i].flush; d4 = tbl[i].d;
         dv4 = tbl[i].dv; tap4 = tbl[i].tap;
         if (tbl[i].clk_it) step();
         else #1;
         chk({tbl[i].name, "_qv"},  qv4,  tbl[i].eqv);
         chk({tbl[i].name, "_cnt"}, cnt4, tbl[i].ecnt);
         if (tbl[i].eqv) chk({tbl[i].name, "_q"}, q4, tbl[i].eq);
      end

      // Random stream with stalls, tap 2, checked against the scoreboard.
      en4 = 1'b0; flush4 = 1'b1; dv4 = 1'b0; tap4 = 2'd2;
      step();
      flush4 = 1'b0;
      en_edges = 0;
      for (int i = 0; i < 68; i++) begin
         if (i < 60) begin
            en4 = ($urandom_range(0, 3) != 0);
            dv4 = $urandom_range(0, 1);
            d4  = 8'($urandom_range(0, 255));
         end else begin
            en4 = 1'b1; dv4 = 1'b0; d4 = 8'h00;       // drain
         end
         step();
         if (en4) begin
            en_edges++;
            if (dv4) begin
               exp_q.push_back(d4);
               lat_q.push_back(en_edges);
            end
            if (qv4) begin
               if (exp_q.size() == 0) begin
                  chk("sb_unexpected", 1, 0);
               end else begin
                  wd  = exp_q.pop_front();
                  lat = lat_q.pop_front();
                  chk("sb_data", q4, wd);
                  chk("sb_latency", en_edges, lat + 2);
               end
            end
         end
      end
      chk("sb_empty", exp_q.size(), 0);

      // Asynchronous reset in mid-cycle while the stages hold data.
      tap4 = 2'd0;
      for (int i = 0; i < 4; i++) begin
         en4 = 1'b1; dv4 = 1'b1; d4 = 8'hC0 + 8'(i);
         step();
      end
      chk("pre_rst_cnt", cnt4, 3'd4);
      #3;
      reset = 1'b0;
      #1;
      chk("arst_q",   q4,   8'h00);
      chk("arst_qv",  qv4,  1'b0);
      chk("arst_cnt", cnt4, 3'd0);
      d4 = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("arst_hold_qv",  qv4,  1'b0);
         chk("arst_hold_cnt", cnt4, 3'd0);
         chk("arst_hold_q",   q4,   8'h00);
      end
      reset = 1'b1;
      d4 = 8'h99; dv4 = 1'b1; en4 = 1'b1;
      step();
      chk("rel_cnt", cnt4, 3'd1);
      chk("rel_qv",  qv4,  1'b1);
      chk("rel_q",   q4,   8'h99);
      en4 = 1'b0; dv4 = 1'b0;

      // DEPTH=5 with tap_sel=7 acts as tap 4: valid after 5 enabled edges.
      tap5 = 3'd7; en5 = 1'b1; d5 = 8'h5A; dv5 = 1'b1;
      step();
      chk("d5_cnt", cnt5, 3'd1);
      d5 = 8'h00; dv5 = 1'b0;
      for (int i = 2; i <= 5; i++) begin
         step();
         if (i < 5) chk("d5_wait_qv", qv5, 1'b0);
      end
      chk("d5_qv", qv5, 1'b1);
      chk("d5_q",  q5,  8'h5A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ffd_delay_line.md
Name: ffd_delay_line

Overview:
- Parametrised multi-stage D flip-flop delay line: WD-bit data, DEPTH register stages, a valid bit tracked alongside every stage.
- Adds clock enable (stall), synchronous flush, a run-time selectable output tap and an occupancy count.
- Drop-in successor to the single-bit FFD for lab datapaths that need a programmable 1..DEPTH cycle delay of a word plus its qualifier.

Parameters:
- WD, 8, data width in bits (>=1).
- DEPTH, 4, number of register stages (>=2).
- RST_VAL, '0, WD-bit value loaded into every data stage on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  shift enable; 0 = hold all stages.
- flush  input  1  synchronous clear of all valid bits.
- d  input  WD  data into stage 0.
- d_valid  input  1  qualifier for d.
- tap_sel  input  TW  output tap index, TW = max(1,$clog2(DEPTH)); delay = tap_sel+1 enabled edges.
- q  output  WD  data at selected tap.
- q_valid  output  1  valid bit at selected tap.
- vld_cnt  output  $clog2(DEPTH+1)  number of stages currently holding valid data.

Behaviour:
- State: data regs s[0..DEPTH-1] (WD bits each) and valid regs v[0..DEPTH-1].
- Reset (reset=0): takes effect immediately, independent of clk.
  - s[i]=RST_VAL, v[i]=0.
  - q=RST_VAL, q_valid=0, vld_cnt=0 within the same delta.
  - Held for as long as reset=0; clk edges are ignored.
  - Deassertion takes effect at the next clk edge with reset=1; release is synchronised externally.
- Reset mid-stream: all in-flight data is discarded with no partial shift.
- Per rising edge (reset=1), priority is flush > en > hold:
  - flush=1: v[all]<=0; s[all] hold; d and d_valid are dropped even if en=1.
  - flush=0, en=1: s[0]<=d, v[0]<=d_valid; s[i]<=s[i-1], v[i]<=v[i-1] for i=1..DEPTH-1; s/v[DEPTH-1] contents are discarded.
  - flush=0, en=0: every stage holds.
- Outputs are combinational from registers, with no added register stage:
  - Tap index k = tap_sel if tap_sel<DEPTH, else DEPTH-1 (clamp; only reachable when DEPTH is not a power of 2).
  - q=s[k], q_valid=v[k].
  - A word sampled at enabled edge n appears on q right after enabled edge n+k. Disabled edges do not count toward latency.
- tap_sel may change at any time; q and q_valid follow in the same cycle with no glitch requirement beyond combinational settle.
- vld_cnt = popcount(v); range 0..DEPTH; all-valid gives DEPTH with no wrap.
- Data stages do not depend on d_valid: invalid words still shift. The bench checks q only when q_valid=1.
- No X propagation from d into v: d_valid=X is a bench error; v[0] captures it unchanged.

Test Plan:
- WD=8, DEPTH=4: drive reset=0 at mid-cycle while stages hold data -> q=8'h00, q_valid=0, vld_cnt=0 before the next clk edge; held 3 edges with reset=0 -> still 0.
- tap_sel=0, en=1, d=8'hA5/d_valid=1 for one edge, then d_valid=0 -> q=8'hA5, q_valid=1 for exactly one cycle after that edge; vld_cnt walks 1,1,1,1,0 over the next 4 edges.
- tap_sel=3, stream 8'h11,8'h22,8'h33,8'h44 on 4 consecutive enabled edges -> after edge 4: q=8'h11, q_valid=1, vld_cnt=4; switching tap_sel to 1 in that cycle -> q=8'h33 immediately.
- Mid-stream en=0 for 2 edges -> q, q_valid and vld_cnt unchanged across both edges; on resuming, sequence continues with no loss or duplication, total latency = tap+1 enabled edges.
- flush=1 with en=1, d=8'h77, d_valid=1 -> after the edge vld_cnt=0 and q_valid=0 at every tap; 8'h77 never appears valid; next enabled valid input yields vld_cnt=1.
- DEPTH=5, tap_sel=7 -> behaves as tap 4: 8'h5A enters and appears valid after 5 enabled edges.
